scope_acq: RTL

SCOPE_ACQ -- requirements
Module: scope_acq

---
 rtl/scope_pkg.sv | 12 +
 rtl/axi4_stream_if.sv | 16 +
 rtl/scope_acq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/scope_pkg.sv
// Shared types for the scope acquisition block.
package scope_pkg;

   // Acquisition FSM states
   typedef enum logic [1:0] {
      StIdle,
      StPre,
      StArm,
      StPost
   } scope_st_e;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle; modport s drives a stream, modport d consumes one.
interface axi4_stream_if #(
   parameter int unsigned DN = 1,
   parameter type         DT = logic signed [16-1:0]
);

   logic          TVALID;
   logic          TREADY;
   DT [DN-1:0]    TDATA;
   logic [DN-1:0] TKEEP;
   logic          TLAST;

   modport s (output TVALID, output TDATA, output TKEEP, output TLAST, input TREADY);
   modport d (input TVALID, input TDATA, input TKEEP, input TLAST, output TREADY);

endinterface

// File: rtl/scope_acq.sv
// Triggered record acquisition on a sample stream: collects cfg_pre pre-trigger beats,
// waits for a qualified trigger, then emits cfg_pst further beats and closes the record
// with TLAST. Optional macro SCOPE_ACQ_TS_EN adds a beat timestamp latched on trigger.
module scope_acq
   import scope_pkg::*;
#(
   parameter int unsigned DN = 1,
   parameter type         DT = logic signed [16-1:0],
   parameter int unsigned CW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ctl_rst,
   input  logic            ctl_acq,
   input  logic            ctl_stp,
   input  logic            cfg_con,
   input  logic [CW-1:0]   cfg_pre,
   input  logic [CW-1:0]   cfg_pst,
   input  logic            trg,
   output logic            sts_acq,
   output logic            sts_trg,
   output logic [CW-1:0]   sts_pre,
   output logic [CW-1:0]   sts_pst,
`ifdef SCOPE_ACQ_TS_EN
   output logic [2*CW-1:0] sts_tsp,
`endif
   axi4_stream_if.d        sti,
   axi4_stream_if.s        sto
);

   scope_st_e     state_q, state_d;
   logic [CW-1:0] pre_q, pre_d, pst_q, pst_d;
   logic [CW-1:0] pre_inc, pst_inc;
   logic          sti_rdy, sti_acc;
   logic          trg_beat, last_beat;
   logic          tvalid_q, tlast_q;
   DT [DN-1:0]    tdata_q;
   logic [DN-1:0] tkeep_q;
   logic          unused_sti_tlast;

   // Records are framed locally; the upstream TLAST carries no meaning here
   assign unused_sti_tlast = sti.TLAST;

   // Input is accepted whenever the single output slot is free or draining
   assign sti_rdy    = sto.TREADY | ~tvalid_q;
   assign sti.TREADY = sti_rdy;
   assign sti_acc    = sti.TVALID & sti_rdy;

   assign pre_inc = (pre_q == '1) ? pre_q : pre_q + CW'(1);
   assign pst_inc = pst_q + CW'(1);

   // The trigger beat itself is not counted as a pre-trigger beat
   assign trg_beat  = sti_acc & (state_q == StArm) & trg;
   assign last_beat = (trg_beat & (cfg_pst == '0)) |
                      (sti_acc & (state_q == StPost) & (pst_inc == cfg_pst));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; soft reset and stop take priority over everything else
   always_comb begin
      state_d = state_q;
      if (ctl_rst || ctl_stp) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: if (ctl_acq) state_d = StPre;
            StPre: begin
               if ((cfg_pre == '0) || (sti_acc && (pre_inc >= cfg_pre))) state_d = StArm;
            end
            StArm, StPost: begin
               if (last_beat)     state_d = cfg_con ? StPre : StIdle;
               else if (trg_beat) state_d = StPost;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Status outputs decoded from the state
   always_comb begin
      sts_acq = (state_q != StIdle);
      sts_trg = (state_q == StPost);
   end

   // Counter next-state; a stop cycle freezes the counters
   always_comb begin
      pre_d = pre_q;
      pst_d = pst_q;
      if (ctl_rst) begin
         pre_d = '0;
         pst_d = '0;
      end else if (!ctl_stp) begin
         case (state_q)
            StIdle: begin
               if (ctl_acq) begin
                  pre_d = '0;
                  pst_d = '0;
               end
            end
            StPre: if (sti_acc) pre_d = pre_inc;
            StArm: begin
               if (trg_beat)     pst_d = '0;
               else if (sti_acc) pre_d = pre_inc;
            end
            StPost: if (sti_acc) pst_d = pst_inc;
            default: ;
         endcase
         // Continuous mode restarts the next record from cleared counters
         if (last_beat && cfg_con) begin
            pre_d = '0;
            pst_d = '0;
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q <= '0;
         pst_q <= '0;
      end else begin
         pre_q <= pre_d;
         pst_q <= pst_d;
      end
   end

   assign sts_pre = pre_q;
   assign sts_pst = pst_q;

   // Output slot control: load on accept (visible only outside idle), clear on drain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else if (ctl_rst) begin
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else if (sti_acc) begin
         tvalid_q <= (state_q != StIdle);
         tlast_q  <= last_beat & ~ctl_stp;
      end else if (sto.TREADY) begin
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end
   end

   // Output payload, deliberately left without reset
   always_ff @(posedge clk) begin
      if (sti_acc) begin
         tdata_q <= sti.TDATA;
         tkeep_q <= sti.TKEEP;
      end
   end

   assign sto.TVALID = tvalid_q;
   assign sto.TLAST  = tlast_q;
   assign sto.TDATA  = tdata_q;
   assign sto.TKEEP  = tkeep_q;

`ifdef SCOPE_ACQ_TS_EN
   logic [2*CW-1:0] ts_q, tsp_q;

   // Free-running accepted-beat counter and its snapshot on the trigger beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_q  <= '0;
         tsp_q <= '0;
      end else if (ctl_rst) begin
         ts_q  <= '0;
         tsp_q <= '0;
      end else begin
         if (sti_acc)              ts_q  <= ts_q + (2*CW)'(1);
         if (trg_beat && !ctl_stp) tsp_q <= ts_q;
      end
   end

   assign sts_tsp = tsp_q;
`endif

endmodule
